// File: rtl/fpu_addsub_seq.sv
// Iterative half-precision add/subtract with valid/ready request and response channels.
// The alignment and normalise shifts move one bit per cycle, so each operation takes several cycles.
module fpu_addsub_seq #(
  parameter int GUARD_BITS = 3,
  parameter int MAX_ALIGN  = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        op,
  input  logic [15:0] Asem,
  input  logic [15:0] Bsem,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] Rsem,
  output logic [2:0]  flags
);
  localparam int MW = 11 + GUARD_BITS;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK, RESP} state_t;
  state_t state;

  logic [15:0]   a_q, b_q;
  logic          sx, sy, rsign, rzero, uflow;
  logic [5:0]    ex;
  logic [4:0]    d;
  logic [MW-1:0] mx, my;
  logic [MW:0]   sum;

  // Larger-magnitude operand becomes X so the subtract never goes negative.
  logic        a_big, a_zero, b_zero;
  logic [15:0] big, sml;
  logic [4:0]  diff;
  logic [MW:0] sum_c;

  assign a_big  = a_q[14:0] >= b_q[14:0];
  assign big    = a_big ? a_q : b_q;
  assign sml    = a_big ? b_q : a_q;
  assign diff   = big[14:10] - sml[14:10];
  assign a_zero = a_q[14:10] == 5'd0;
  assign b_zero = b_q[14:10] == 5'd0;
  assign sum_c  = (sx == sy) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      Rsem      <= 16'h0000;
      flags     <= 3'b000;
      a_q       <= '0;
      b_q       <= '0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      rsign     <= 1'b0;
      rzero     <= 1'b0;
      uflow     <= 1'b0;
      ex        <= '0;
      d         <= '0;
      mx        <= '0;
      my        <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_q       <= Asem;
          b_q       <= {Bsem[15] ^ op, Bsem[14:0]};
          req_ready <= 1'b0;
          state     <= UNPACK;
        end
        UNPACK: begin
          if (a_q[14:10] == 5'h1f || b_q[14:10] == 5'h1f) begin
            Rsem <= 16'h7E00; flags <= 3'b100; rsp_valid <= 1'b1; state <= RESP;
          end else if (a_zero && b_zero) begin
            Rsem <= 16'h0000; flags <= 3'b000; rsp_valid <= 1'b1; state <= RESP;
          end else if (a_zero || b_zero) begin
            Rsem <= a_zero ? b_q : a_q; flags <= 3'b000; rsp_valid <= 1'b1; state <= RESP;
          end else begin
            sx    <= big[15];
            sy    <= sml[15];
            ex    <= {1'b0, big[14:10]};
            d     <= diff;
            mx    <= {1'b1, big[9:0], {GUARD_BITS{1'b0}}};
            my    <= {1'b1, sml[9:0], {GUARD_BITS{1'b0}}};
            state <= (diff == 5'd0) ? ADD : ALIGN;
          end
        end
        ALIGN: begin
          if (d > 5'(MAX_ALIGN)) begin
            my <= '0; d <= '0; state <= ADD;
          end else begin
            my <= my >> 1;
            d  <= d - 5'd1;
            if (d == 5'd1) state <= ADD;
          end
        end
        ADD: begin
          sum   <= sum_c;
          uflow <= 1'b0;
          rzero <= (sum_c == '0);
          rsign <= (sum_c == '0) ? 1'b0 : sx;
          // Already normalised (or exactly zero) results skip NORM entirely.
          if (sum_c == '0 || (!sum_c[MW] && sum_c[MW-1])) state <= PACK;
          else state <= NORM;
        end
        NORM: begin
          if (sum[MW]) begin
            sum <= sum >> 1; ex <= ex + 6'd1; state <= PACK;
          end else if (ex == 6'd1) begin
            rzero <= 1'b1; uflow <= 1'b1; state <= PACK;
          end else begin
            sum <= sum << 1;
            ex  <= ex - 6'd1;
            if (sum[MW-2]) state <= PACK;
          end
        end
        PACK: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
          if (rzero) begin
            Rsem <= {rsign, 15'h0000}; flags <= {2'b00, uflow};
          end else if (ex >= 6'd31) begin
            Rsem <= {rsign, 5'h1f, 10'h000}; flags <= 3'b010;
          end else begin
            Rsem <= {rsign, ex[4:0], sum[MW-2:GUARD_BITS]}; flags <= 3'b000;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Self-checking bench for fpu_addsub_seq: directed cases plus random operands against an arithmetic model.
module tb_fpu_addsub_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, op = 1'b0, rsp_ready = 1'b0;
  logic [15:0] Asem = '0, Bsem = '0;
  logic        req_ready, rsp_valid;
  logic [15:0] Rsem;
  logic [2:0]  flags;
  int          errs = 0, checks = 0;

  fpu_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .Asem(Asem), .Bsem(Bsem), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .Rsem(Rsem), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the half-precision fields.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] bi, input logic o,
                                    output logic [15:0] r, output logic [2:0] f, output int lat);
    logic [15:0] b, x, y;
    int ex, ey, d, mx, my, s, e, ac, nc;
    logic sg;
    b = {bi[15] ^ o, bi[14:0]};
    f = 3'b000; lat = 2; r = 16'h0000;
    if (a[14:10] == 5'd31 || b[14:10] == 5'd31) begin r = 16'h7E00; f = 3'b100; return; end
    if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return;
    if (a[14:10] == 5'd0) begin r = b; return; end
    if (b[14:10] == 5'd0) begin r = a; return; end
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end else begin x = b; y = a; end
    ex = int'(x[14:10]); ey = int'(y[14:10]); d = ex - ey;
    mx = (1024 + int'(x[9:0])) * 8;
    my = (1024 + int'(y[9:0])) * 8;
    ac = (d > 13) ? 1 : d;
    my = (d > 13) ? 0 : (my >> d);
    s = (x[15] == y[15]) ? mx + my : mx - my;
    e = ex; sg = x[15]; nc = 0;
    if (s == 0) sg = 1'b0;
    else if (s >= 16384) begin s = s / 2; e++; nc = 1; end
    else while (s < 8192) begin
      nc++;
      if (e == 1) begin s = 0; f = 3'b001; break; end
      s = s * 2; e--;
    end
    lat = 4 + ac + nc;
    if (s == 0) r = {sg, 15'h0000};
    else if (e >= 31) begin r = {sg, 5'h1f, 10'h000}; f = 3'b010; end
    else r = {sg, 5'(e), 10'((s / 8) % 1024)};
  endfunction

  // Issue one request, check result, latency and hold stability, then complete the handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic o, input int hold,
                        input logic [15:0] er, input logic [2:0] ef, input int el);
    int lat;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    Asem = a; Bsem = b; op = o; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; Asem = 16'($urandom); Bsem = 16'($urandom); op = 1'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 64);
    if (!rsp_valid) begin chk("timeout", 0, 1); return; end
    chk($sformatf("rsem %h%s%h", a, o ? "-" : "+", b), Rsem, er);
    chk("flags", flags, ef);
    chk("latency", lat, el);
    chk("req_ready_busy", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rsem", Rsem, er);
      chk("hold_flags", flags, ef);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  task automatic run_rand(input logic [15:0] a, input logic [15:0] b, input logic o, input int hold);
    logic [15:0] r; logic [2:0] f; int lat;
    ref_model(a, b, o, r, f, lat);
    run_op(a, b, o, hold, r, f, lat);
  endtask

  function automatic logic [15:0] rnd_fp(input logic [4:0] near, input logic use_near);
    logic [4:0] e;
    int k;
    k = int'($urandom_range(0, 15));
    if (k == 0) e = 5'd0;
    else if (k == 1) e = 5'd31;
    else if (use_near) begin
      k = int'(near) + int'($urandom_range(0, 6)) - 3;
      e = (k < 1) ? 5'd1 : (k > 30) ? 5'd30 : 5'(k);
    end else e = 5'($urandom_range(1, 30));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  initial begin
    int seen;
    logic [15:0] a, b;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsem", Rsem, 0);
    chk("rst_flags", flags, 0);
    rst_n = 1'b1;

    run_op(16'hCA60, 16'hC460, 1'b0, 0, 16'hCC48, 3'b000, 6);
    run_op(16'h4400, 16'hC400, 1'b0, 0, 16'h0000, 3'b000, 4);
    run_op(16'h542C, 16'h540C, 1'b1, 0, 16'h4000, 3'b000, 9);
    run_op(16'h0000, 16'hC000, 1'b0, 0, 16'hC000, 3'b000, 2);
    run_op(16'hC129, 16'h8000, 1'b0, 0, 16'hC129, 3'b000, 2);
    run_op(16'h7BFF, 16'h7BFF, 1'b0, 0, 16'h7C00, 3'b010, 5);
    run_op(16'h7C00, 16'h3C00, 1'b0, 0, 16'h7E00, 3'b100, 2);
    run_op(16'h0401, 16'h0400, 1'b1, 0, 16'h0000, 3'b001, 5);
    run_op(16'h5000, 16'h1800, 1'b0, 0, 16'h5000, 3'b000, 5);
    run_op(16'h8000, 16'h0000, 1'b0, 0, 16'h0000, 3'b000, 2);
    run_op(16'hCA60, 16'h4460, 1'b1, 5, 16'hCC48, 3'b000, 6);

    // Reset in the middle of a long alignment must kill the operation outright.
    @(negedge clk);
    Asem = 16'h7000; Bsem = 16'h3C00; op = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsem", Rsem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("abort_no_rsp", seen, 0);
    chk("abort_idle", req_ready, 1);

    for (int n = 0; n < 150; n++) begin
      a = rnd_fp(5'd15, 1'b0);
      if ($urandom_range(0, 7) == 0) b = {1'($urandom), a[14:0] ^ 15'($urandom_range(0, 63))};
      else b = rnd_fp(a[14:10], 1'($urandom));
      run_rand(a, b, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
